// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: turns the UART byte stream into command frames
// (LEN_H, LEN_L, CMD, LEN payload bytes; LEN big-endian). It drives the SD
// command strobes and sector-address register, streams CMD 0x01 payload into
// the TX FIFO, and aborts a partial frame after an inter-byte gap.
// Handshake: a byte is consumed on every clk edge where rx_valid is high;
// there is no back-pressure toward the receiver. fifo_wr_en is a one-cycle
// write strobe and fifo_full is sampled with the byte that would be written.
module uart_cmd_parser #(
    parameter int TIMEOUT_CYC = 500000,
    parameter int CNT_W       = $clog2(TIMEOUT_CYC)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        fifo_full,
    output logic        fifo_wr_en,
    output logic [7:0]  fifo_wr_data,
    output logic        cmd_init_sd,
    output logic        cmd_read_sd,
    output logic        cmd_write_sd,
    output logic [31:0] sec_addr,
    output logic        frame_done,
    output logic        frame_err,
    output logic [2:0]  err_code,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_LEN_H = 2'd0,
        S_LEN_L = 2'd1,
        S_CMD   = 2'd2,
        S_PAY   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [15:0] pay_cnt_q, pay_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        ovf_q, ovf_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] sec_q, sec_d;
    logic [2:0]  code_q, code_d;
    logic        wr_en_q, wr_en_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        init_q, init_d, read_q, read_d, write_q, write_d;
    logic        done_q, done_d, err_q, err_d;
    logic        fin;
    logic [7:0]  fin_cmd;

    // State, frame bookkeeping and registered output strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_LEN_H;
            len_q     <= '0;
            cmd_q     <= '0;
            pay_cnt_q <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            hold_q    <= '0;
            sec_q     <= '0;
            code_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            init_q    <= 1'b0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cmd_q     <= cmd_d;
            pay_cnt_q <= pay_cnt_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            hold_q    <= hold_d;
            sec_q     <= sec_d;
            code_q    <= code_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            init_q    <= init_d;
            read_q    <= read_d;
            write_q   <= write_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Next-state: byte parsing, payload routing, frame completion, timeout.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cmd_d     = cmd_q;
        pay_cnt_d = pay_cnt_q;
        ovf_d     = ovf_q;
        hold_d    = hold_q;
        sec_d     = sec_q;
        code_d    = code_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        init_d    = 1'b0;
        read_d    = 1'b0;
        write_d   = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        fin       = 1'b0;
        fin_cmd   = cmd_q;
        cnt_d     = (rx_valid || state_q == S_LEN_H) ? '0 : cnt_q + CNT_W'(1);

        case (state_q)
            S_LEN_H: if (rx_valid) begin
                len_d[15:8] = rx_data;
                state_d     = S_LEN_L;
            end
            S_LEN_L: if (rx_valid) begin
                len_d[7:0] = rx_data;
                ovf_d      = 1'b0;   // fresh frame: no dropped bytes yet
                hold_d     = '0;
                state_d    = S_CMD;
            end
            S_CMD: if (rx_valid) begin
                cmd_d   = rx_data;
                fin_cmd = rx_data;   // zero-length frame completes on CMD
                if (len_q == 16'd0) begin
                    fin     = 1'b1;
                    state_d = S_LEN_H;
                end else begin
                    pay_cnt_d = len_q;
                    state_d   = S_PAY;
                end
            end
            S_PAY: if (rx_valid) begin
                pay_cnt_d = pay_cnt_q - 16'd1;
                if (cmd_q == 8'h01) begin
                    if (fifo_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_data_d = rx_data;
                    end
                end
                if (cmd_q == 8'h05) begin
                    hold_d = {hold_q[23:0], rx_data};
                end
                if (pay_cnt_q == 16'd1) begin
                    fin     = 1'b1;
                    state_d = S_LEN_H;
                end
            end
            default: state_d = S_LEN_H;
        endcase

        // Completion uses the _d views so the final byte is included.
        if (fin) begin
            case (fin_cmd)
                8'h01: begin
                    if (ovf_d) begin
                        err_d  = 1'b1;
                        code_d = 3'd4;
                    end else begin
                        done_d = 1'b1;
                    end
                end
                8'h02: begin init_d  = 1'b1; done_d = 1'b1; end
                8'h03: begin read_d  = 1'b1; done_d = 1'b1; end
                8'h04: begin write_d = 1'b1; done_d = 1'b1; end
                8'h05: begin
                    if (len_q == 16'd4) begin
                        sec_d  = hold_d;
                        done_d = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                        code_d = 3'd2;
                    end
                end
                default: begin
                    err_d  = 1'b1;
                    code_d = 3'd1;
                end
            endcase
        end

        // Inter-byte gap expired; a byte arriving on the same edge wins.
        if (!rx_valid && state_q != S_LEN_H && cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            state_d = S_LEN_H;
            err_d   = 1'b1;
            code_d  = 3'd3;
            cnt_d   = '0;
        end
    end

    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = wr_data_q;
    assign cmd_init_sd  = init_q;
    assign cmd_read_sd  = read_q;
    assign cmd_write_sd = write_q;
    assign sec_addr     = sec_q;
    assign frame_done   = done_q;
    assign frame_err    = err_q;
    assign err_code     = code_q;
    assign busy         = (state_q != S_LEN_H);
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: frame-level reference model, per-cycle compare,
// FIFO scoreboard and hand-computed expectations for each directed scenario.
module tb_uart_cmd_parser;
  localparam int TIMEOUT = 40;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        fifo_full = 1'b0;
  logic        fifo_wr_en;
  logic [7:0]  fifo_wr_data;
  logic        cmd_init_sd, cmd_read_sd, cmd_write_sd;
  logic [31:0] sec_addr;
  logic        frame_done, frame_err;
  logic [2:0]  err_code;
  logic        busy;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  uart_cmd_parser #(.TIMEOUT_CYC(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .cmd_init_sd(cmd_init_sd), .cmd_read_sd(cmd_read_sd), .cmd_write_sd(cmd_write_sd),
    .sec_addr(sec_addr), .frame_done(frame_done), .frame_err(frame_err),
    .err_code(err_code), .busy(busy), .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;
  logic started = 1'b0;

  // ---------------- reference model ----------------
  // Keeps the bytes of the frame in progress; a frame is complete once
  // 3 + LEN bytes have arrived, and is judged from its CMD byte.
  logic [7:0]  m_frm[$];
  int          m_idle = 0;
  logic        m_ovf = 1'b0;
  int          m_len;
  logic        e_wr_en = 0, e_init = 0, e_read = 0, e_write = 0, e_done = 0, e_err = 0;
  logic [2:0]  e_code = 0;
  logic [31:0] e_sec = 0;
  logic        e_busy = 0;
  logic [7:0]  exp_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_frm.delete();
      m_idle = 0; m_ovf = 0;
      e_wr_en = 0; e_init = 0; e_read = 0; e_write = 0; e_done = 0; e_err = 0;
      e_code = 0; e_sec = 0; e_busy = 0;
    end else begin
      e_wr_en = 0; e_init = 0; e_read = 0; e_write = 0; e_done = 0; e_err = 0;
      if (rx_valid) begin
        m_frm.push_back(rx_data);
        m_idle = 0;
        if (m_frm.size() >= 4 && m_frm[2] == 8'h01) begin
          if (fifo_full) m_ovf = 1;
          else begin
            e_wr_en = 1;
            exp_q.push_back(rx_data);
          end
        end
        if (m_frm.size() >= 3) begin
          m_len = {16'h0, m_frm[0], m_frm[1]};
          if (m_frm.size() == 3 + m_len) begin
            case (m_frm[2])
              8'h01: if (m_ovf) begin e_err = 1; e_code = 4; end else e_done = 1;
              8'h02: begin e_init = 1; e_done = 1; end
              8'h03: begin e_read = 1; e_done = 1; end
              8'h04: begin e_write = 1; e_done = 1; end
              8'h05: if (m_len == 4) begin
                       e_sec = {m_frm[3], m_frm[4], m_frm[5], m_frm[6]};
                       e_done = 1;
                     end else begin e_err = 1; e_code = 2; end
              default: begin e_err = 1; e_code = 1; end
            endcase
            m_frm.delete();
            m_ovf = 0;
          end
        end
      end else if (m_frm.size() != 0) begin
        m_idle++;
        if (m_idle == TIMEOUT) begin
          e_err = 1; e_code = 3;
          m_frm.delete();
          m_ovf = 0; m_idle = 0;
        end
      end
      e_busy = (m_frm.size() != 0);
    end
  end

  // ---------------- compare / scoreboard / event counters ----------------
  int init_cnt = 0, read_cnt = 0, write_cnt = 0, done_cnt = 0, err_cnt = 0, coinc_cnt = 0;
  int exp_rd = 0;
  logic [7:0] act_q[$];
  logic [41:0] got_v, exp_v;

  always @(negedge clk) begin
    if (started) begin
      got_v = {fifo_wr_en, cmd_init_sd, cmd_read_sd, cmd_write_sd, frame_done, frame_err,
               err_code, sec_addr, busy};
      exp_v = {e_wr_en, e_init, e_read, e_write, e_done, e_err, e_code, e_sec, e_busy};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL cycle_compare t=%0t got=%h exp=%h", $time, got_v, exp_v);
      end
      if (fifo_wr_en === 1'b1) begin
        act_q.push_back(fifo_wr_data);
        checks++;
        if (exp_rd >= exp_q.size()) begin
          errors++;
          $display("FAIL fifo_unexpected t=%0t got=%h exp=none", $time, fifo_wr_data);
        end else begin
          if (fifo_wr_data !== exp_q[exp_rd]) begin
            errors++;
            $display("FAIL fifo_data t=%0t got=%h exp=%h", $time, fifo_wr_data, exp_q[exp_rd]);
          end
          exp_rd++;
        end
      end
      if (cmd_init_sd) init_cnt++;
      if (cmd_read_sd) read_cnt++;
      if (cmd_write_sd) write_cnt++;
      if (frame_done) done_cnt++;
      if (frame_err) err_cnt++;
      if (cmd_init_sd && frame_done) coinc_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_byte(input logic [7:0] b, input logic full);
    rx_valid = 1'b1; rx_data = b; fifo_full = full;
    @(posedge clk);
    #1;
    rx_valid = 1'b0; fifo_full = 1'b0;
  endtask

  // Sends bytes on consecutive cycles.
  task automatic send4(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) drive_byte(w[31-8*i -: 8], 1'b0);
  endtask

  int b_init, b_read, b_write, b_done, b_err, b_coinc, b_wr;

  task automatic snap();
    b_init = init_cnt; b_read = read_cnt; b_write = write_cnt;
    b_done = done_cnt; b_err = err_cnt; b_coinc = coinc_cnt; b_wr = act_q.size();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    started = 1'b1;
    idle(1);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_sec", sec_addr, 32'h0);
    check("reset_code", {29'h0, err_code}, 32'h0);
    check("reset_state", {30'h0, state_dbg}, 32'h0);

    // init command, zero payload
    snap();
    send4(32'h00010200, 4);
    idle(2);
    check("t1_init", init_cnt - b_init, 1);
    check("t1_done", done_cnt - b_done, 1);
    check("t1_coinc", coinc_cnt - b_coinc, 1);
    check("t1_nowr", act_q.size() - b_wr, 0);
    check("t1_busy", {31'h0, busy}, 32'h0);

    // sector address load, then bad length
    snap();
    send4(32'h00040512, 4);
    send4(32'h345678_00, 3);
    idle(2);
    check("t2_sec", sec_addr, 32'h12345678);
    check("t2_done", done_cnt - b_done, 1);
    snap();
    send4(32'h000205AA, 4);
    send4(32'hBB000000, 1);
    idle(2);
    check("t2_err", err_cnt - b_err, 1);
    check("t2_code", {29'h0, err_code}, 32'd2);
    check("t2_sec_hold", sec_addr, 32'h12345678);

    // FIFO stream with one dropped byte
    snap();
    send4(32'h000301A5, 4);
    drive_byte(8'h5A, 1'b1);
    drive_byte(8'hC3, 1'b0);
    idle(2);
    check("t3_wrcnt", act_q.size() - b_wr, 2);
    check("t3_wr0", {24'h0, act_q[b_wr]}, 32'hA5);
    check("t3_wr1", {24'h0, act_q[b_wr+1]}, 32'hC3);
    check("t3_err", err_cnt - b_err, 1);
    check("t3_code", {29'h0, err_code}, 32'd4);
    snap();
    send4(32'h000301A5, 4);
    send4(32'h5AC30000, 2);
    idle(2);
    check("t3b_wrcnt", act_q.size() - b_wr, 3);
    check("t3b_wr1", {24'h0, act_q[b_wr+1]}, 32'h5A);
    check("t3b_done", done_cnt - b_done, 1);

    // back-to-back frames
    snap();
    send4(32'h00010300, 4);
    send4(32'h00010400, 4);
    idle(2);
    check("t4_read", read_cnt - b_read, 1);
    check("t4_write", write_cnt - b_write, 1);
    check("t4_done", done_cnt - b_done, 2);

    // timeout mid-payload
    snap();
    send4(32'h00050100, 3);
    for (int i = 0; i < TIMEOUT + 5 && err_cnt == b_err; i++) idle(1);
    check("t5_err", err_cnt - b_err, 1);
    check("t5_code", {29'h0, err_code}, 32'd3);
    check("t5_state", {30'h0, state_dbg}, 32'h0);
    check("t5_done", done_cnt - b_done, 0);
    snap();
    send4(32'h00010200, 4);
    idle(2);
    check("t5_next_init", init_cnt - b_init, 1);
    check("t5_next_done", done_cnt - b_done, 1);

    // byte arriving on the expiry edge wins
    snap();
    send4(32'h00010300, 3);
    idle(TIMEOUT - 1);
    drive_byte(8'h00, 1'b0);
    idle(2);
    check("t5b_read", read_cnt - b_read, 1);
    check("t5b_noerr", err_cnt - b_err, 0);

    // unknown command; len 0 sector load
    snap();
    send4(32'h00020911, 4);
    send4(32'h22000000, 1);
    idle(2);
    check("t6_err", err_cnt - b_err, 1);
    check("t6_code", {29'h0, err_code}, 32'd1);
    check("t6_strobes", (init_cnt - b_init) + (read_cnt - b_read) + (write_cnt - b_write), 0);
    snap();
    send4(32'h00000500, 3);
    idle(2);
    check("t6b_code", {29'h0, err_code}, 32'd2);
    check("t6b_sec", sec_addr, 32'h12345678);

    // reset mid-frame
    send4(32'h00040000, 2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(1);
    check("t7_sec", sec_addr, 32'h0);
    check("t7_code", {29'h0, err_code}, 32'h0);
    check("t7_busy", {31'h0, busy}, 32'h0);
    snap();
    send4(32'h00010300, 4);
    idle(2);
    check("t7_read", read_cnt - b_read, 1);
    check("t7_done", done_cnt - b_done, 1);
    check("fifo_all_seen", exp_rd, exp_q.size());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
